dac_sample_feeder: RTL and testbench

Buffers paired signed samples for the two on-board 14-bit DACs and releases them at a programmable sample rate. Converts them to the offset-binary words the DAC output stage drives onto da1_data/da2_data. Sits directly upstream of the DAC ODDR output stage, in the sys_clk domain, fed by a LiteX stream or CSR writer. Provides underflow accounting and a defined mid-scale idle level.

---
 rtl/dac_sample_feeder.sv | 151 +++++++++++++++
 tb/tb_dac_sample_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_feeder.sv
// Sample-pair FIFO feeding the two 14-bit DACs at a programmable rate.
// Inputs are signed samples; outputs are offset-binary words that idle at mid-scale.
module dac_sample_feeder #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PRIME_LEVEL = 8
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [7:0]              rate_div,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [15:0]             s_data1,
  input  logic [15:0]             s_data2,
  output logic [13:0]             dac1_data,
  output logic [13:0]             dac2_data,
  output logic                    sample_stb,
  output logic                    running,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             underflow_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_MARK  = LW'(PRIME_LEVEL);
  localparam logic [13:0]   MID_SCALE   = 14'h2000;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t          state, state_nx;
  logic [13:0]     mem1 [DEPTH];
  logic [13:0]     mem2 [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      div_cnt;
  logic            armed;
  logic            flush, tick, push, pop, underrun;
  logic [13:0]     conv1, conv2;
  logic            unused_lsbs;

  // Offset binary: invert the sign bit, drop the two LSBs.
  assign conv1       = {~s_data1[15], s_data1[14:2]};
  assign conv2       = {~s_data2[15], s_data2[14:2]};
  assign unused_lsbs = ^{s_data1[1:0], s_data2[1:0]};

  assign s_ready = (level != FULL_LEVEL);

  always_comb begin
    state_nx = state;
    flush    = 1'b0;
    case (state)
      IDLE:  if (enable) state_nx = PRIME;
      PRIME: begin
        if (!enable) begin
          state_nx = IDLE;
          flush    = 1'b1;
        end else if (level >= PRIME_MARK) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nx = IDLE;
          flush    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The divider is held for the first RUN cycle so the first tick lands rate_div+1 cycles after running rises.
  assign tick     = (state == RUN) && enable && armed && (div_cnt == rate_div);
  assign pop      = tick && (level != '0);
  assign underrun = tick && (level == '0);
  assign push     = s_valid && s_ready && !flush;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= (state_nx == RUN);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      div_cnt <= '0;
    end else if (state != RUN || state_nx != RUN) begin
      armed   <= 1'b0;
      div_cnt <= '0;
    end else if (!armed) begin
      armed   <= 1'b1;
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem1[wr_ptr] <= conv1;
      mem2[wr_ptr] <= conv2;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      dac1_data     <= MID_SCALE;
      dac2_data     <= MID_SCALE;
      sample_stb    <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      sample_stb <= pop;
      if (state_nx == IDLE) begin
        dac1_data <= MID_SCALE;
        dac2_data <= MID_SCALE;
      end else if (pop) begin
        dac1_data <= mem1[rd_ptr];
        dac2_data <= mem2[rd_ptr];
      end
      if (underrun && underflow_cnt != '1)
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Bench for dac_sample_feeder: queue of expected word pairs filled on accepted pushes,
// drained and compared on every sample_stb; cycle-exact checks of timing and status.
module tb_dac_sample_feeder;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  rate_div;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data1, s_data2;
  logic [13:0] dac1_data, dac2_data;
  logic        sample_stb;
  logic        running;
  logic [4:0]  level;
  logic [15:0] underflow_cnt;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [27:0] exp_q [$];
  logic [27:0] last_pair;
  int unsigned seq;

  dac_sample_feeder #(.DEPTH(16), .PRIME_LEVEL(8)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .rate_div(rate_div),
    .s_valid(s_valid), .s_ready(s_ready), .s_data1(s_data1), .s_data2(s_data2),
    .dac1_data(dac1_data), .dac2_data(dac2_data), .sample_stb(sample_stb),
    .running(running), .level(level), .underflow_cnt(underflow_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Arithmetic reference: shift signed range up by half scale, then keep the top 14 bits.
  function automatic logic [13:0] ref_conv(input logic [15:0] d);
    int v;
    v = $signed(d) + 32768;
    return 14'(v >> 2);
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_pair(input logic [15:0] d1, input logic [15:0] d2);
    s_valid = 1'b1;
    s_data1 = d1;
    s_data2 = d2;
    if (s_ready) exp_q.push_back({ref_conv(d1), ref_conv(d2)});
    step();
    s_valid = 1'b0;
  endtask

  task automatic offer_seq();
    logic [15:0] d;
    d = 16'(seq << 2);
    s_valid = 1'b1;
    s_data1 = d;
    s_data2 = ~d;
    if (s_ready) begin
      exp_q.push_back({ref_conv(d), ref_conv(~d)});
      seq++;
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    #2;
    check("arst_dac1", dac1_data, 14'h2000);
    check("arst_running", running, 0);
    check("arst_level", level, 0);
    check("arst_uf", underflow_cnt, 0);
    step();
    step();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  always @(negedge sys_clk) begin
    if (sample_stb) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'(exp_q.size()), 1);
      end else begin
        last_pair = exp_q.pop_front();
        check("sb_dac1", dac1_data, last_pair[27:14]);
        check("sb_dac2", dac2_data, last_pair[13:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] hold_pair;
    bit found;
    rst_n    = 1'b0;
    enable   = 1'b0;
    rate_div = 8'd0;
    s_valid  = 1'b0;
    s_data1  = '0;
    s_data2  = '0;
    seq      = 0;

    // Reset held with activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      enable  = (i % 2) == 0;
      s_valid = (i % 2) == 1;
      s_data1 = 16'($urandom);
      step();
      check("rst_dac1", dac1_data, 14'h2000);
      check("rst_dac2", dac2_data, 14'h2000);
      check("rst_ready", s_ready, 1);
      check("rst_level", level, 0);
      check("rst_stb", sample_stb, 0);
    end
    enable  = 1'b0;
    s_valid = 1'b0;
    rst_n   = 1'b1;
    step();

    // Conversion and latency at rate_div=0.
    rate_div = 8'd0;
    push_pair(16'h7FFF, 16'h8000);
    push_pair(16'h0000, 16'hFFFC);
    for (int i = 0; i < 6; i++) push_pair(16'($urandom), 16'($urandom));
    check("prime_level", level, 8);
    check("idle_running", running, 0);
    enable = 1'b1;
    step();
    check("run_prime", running, 0);
    step();
    check("run_rise", running, 1);
    step();
    check("stb_lat", sample_stb, 0);
    step();
    check("first_dac1", dac1_data, 14'h3FFF);
    check("first_dac2", dac2_data, 14'h0000);
    for (int i = 1; i < 8; i++) begin
      step();
      check("stb_burst", sample_stb, 1);
      if (i == 1) begin
        check("second_dac1", dac1_data, 14'h2000);
        check("second_dac2", dac2_data, 14'h1FFF);
      end
    end
    step();
    check("stb_drained", sample_stb, 0);
    do_reset();

    // Rate divider at rate_div=3 with the FIFO kept fed.
    rate_div = 8'd3;
    for (int i = 0; i < 8; i++) push_pair(16'($urandom), 16'($urandom));
    enable = 1'b1;
    push_pair(16'($urandom), 16'($urandom));
    check("div_prime", running, 0);
    push_pair(16'($urandom), 16'($urandom));
    check("div_rise", running, 1);
    for (int k = 1; k <= 24; k++) begin
      push_pair(16'($urandom), 16'($urandom));
      check("div_stb", sample_stb, (k >= 5 && ((k - 5) % 4) == 0) ? 1 : 0);
    end
    do_reset();

    // Underflow at rate_div=1 after an 8-pair prime.
    rate_div = 8'd1;
    for (int i = 0; i < 8; i++) push_pair(16'($urandom), 16'($urandom));
    hold_pair = exp_q[7];
    enable = 1'b1;
    step();
    step();
    check("uf_rise", running, 1);
    for (int k = 1; k <= 30; k++) begin
      step();
      check("uf_running", running, 1);
      if (k >= 17) check("uf_hold", {dac1_data, dac2_data}, hold_pair);
      if (k >= 18) check("uf_nostb", sample_stb, 0);
      check("uf_cnt", underflow_cnt, (k >= 19) ? (k - 17) / 2 : 0);
    end
    enable = 1'b0;
    step();
    check("uf_off_run", running, 0);
    check("uf_off_dac", dac1_data, 14'h2000);
    check("uf_keep", underflow_cnt, 6);

    // Full FIFO, then coincident push and pop with sequence-numbered data.
    rate_div = 8'd0;
    for (int i = 0; i < 16; i++) offer_seq();
    check("full_level", level, 16);
    check("full_ready", s_ready, 0);
    offer_seq();
    check("full_refuse", level, 16);
    check("full_seq", seq, 16);
    enable = 1'b1;
    offer_seq();
    offer_seq();
    check("full_rise", running, 1);
    for (int k = 1; k <= 20; k++) begin
      offer_seq();
      if (k >= 2) check("lvl_const", level, 15);
    end

    // Drain to five entries, then drop enable with a push in the flush cycle.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (level == 5) found = 1'b1;
    end
    check("lvl5_reached", found, 1);
    enable  = 1'b0;
    s_valid = 1'b1;
    s_data1 = 16'h1234;
    s_data2 = 16'h4321;
    step();
    s_valid = 1'b0;
    exp_q.delete();
    check("dis_level", level, 0);
    check("dis_dac1", dac1_data, 14'h2000);
    check("dis_dac2", dac2_data, 14'h2000);
    check("dis_running", running, 0);
    check("dis_uf", underflow_cnt, 6);
    step();
    check("dis_stb", sample_stb, 0);
    check("dis_level2", level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
